ws281x_chain_ctrl: RTL and testbench

Parametrised successor of the single-strip WS281x frame controller. Walks a linked list of pixel words in RAM from a programmable head address and streams pixel bits over a valid/ready handshake to the bit-code encoder. Closes each frame with a programmable reset/latch period. Adds RGBW pixel width, programmable bit order, auto-repeat, abort, a runaway-chain guard and status outputs. Sits between the RAM write-side logic and the WS281x bit encoder.

---
 rtl/ws281x_pkg.sv | 37 +++
 rtl/ws281x_chain_ctrl_shifter.sv | 57 +++++
 rtl/ws281x_chain_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ws281x_chain_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws281x_pkg.sv
// ---------------------------------------------------------------------------
// ws281x_pkg
// Shared types and helpers for the WS281x chain controller.
//   state_t     : controller FSM states
//   PIX_GRB     : pixel width of a plain RGB strip (G,R,B bytes)
//   PIX_GRBW    : pixel width of an RGBW strip (G,R,B,W bytes)
//   word_pixel  : pixel field [pix_w-1:0] of a RAM list word
//   word_next   : next-pointer field [.. :pix_w] of a RAM list word
// ---------------------------------------------------------------------------
package ws281x_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      SYNC
   } state_t;

   localparam int PIX_GRB    = 24;
   localparam int PIX_GRBW   = 32;

   // Words are handed to the helpers zero-extended to this width so one
   // function serves every ADDR_W/PIX_W combination.
   localparam int WORD_MAX_W = 64;

   function automatic logic [31:0] word_pixel(input logic [WORD_MAX_W-1:0] word,
                                              input int pix_w);
      return 32'(word & ((64'd1 << pix_w) - 64'd1));
   endfunction

   function automatic logic [31:0] word_next(input logic [WORD_MAX_W-1:0] word,
                                             input int pix_w);
      return 32'(word >> pix_w);
   endfunction

endpackage

// File: rtl/ws281x_chain_ctrl_shifter.sv
// ---------------------------------------------------------------------------
// ws281x_pix_shifter
// Holds one pixel and presents its bits one at a time.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : load pix_i and restart the bit count
//   pix_i          : pixel to load
//   msb_first_i    : 1 = present bit PIX_W-1 first, 0 = bit 0 first
//   shift_i        : current bit was accepted, advance to the next one
//   bit_o          : current bit
//   last_o         : current bit is the last one of the pixel
// ---------------------------------------------------------------------------
module ws281x_pix_shifter
   import ws281x_pkg::*;
#(
   parameter  int PIX_W = PIX_GRB,
   localparam int CNT_W = $clog2(PIX_W)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [PIX_W-1:0] pix_i,
   input  logic             msb_first_i,
   input  logic             shift_i,
   output logic             bit_o,
   output logic             last_o
);

   logic [PIX_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   // The outgoing bit always sits at the end the register shifts away from.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = pix_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         sreg_d = msb_first_i ? (sreg_q << 1) : (sreg_q >> 1);
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bit_o  = msb_first_i ? sreg_q[PIX_W-1] : sreg_q[0];
   assign last_o = (cnt_q == CNT_W'(PIX_W - 1));

endmodule

// File: rtl/ws281x_chain_ctrl.sv
// ---------------------------------------------------------------------------
// ws281x_chain_ctrl
// Walks a linked list of pixel words in RAM and streams their bits to the
// WS281x bit encoder, then holds the line low for the reset/latch period.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   start_i                 : start a frame (only honoured in IDLE)
//   abort_i                 : cut the current frame short, still latch strip
//   loop_i                  : restart the frame after each reset period
//   msb_first_i             : bit order, latched at start
//   head_addr_i             : first list word, latched at start
//   rst_cnt_i               : reset period in cycles (0 acts as 1), latched
//   rd_en_o, rd_addr_o      : RAM read strobe and address
//   rd_data_i               : RAM word {next pointer, pixel}
//   bit_vld_o, bit_data_o   : bit stream towards the encoder
//   bit_rdy_i               : encoder ready
//   busy_o, done_o, err_o   : status (done pulses at end of reset period,
//                             err flags a chain that never returns to head)
//   pix_cnt_o               : pixels fully sent in the current frame
// ---------------------------------------------------------------------------
module ws281x_chain_ctrl
   import ws281x_pkg::*;
#(
   parameter  int ADDR_W  = 6,
   parameter  int PIX_W   = PIX_GRB,
   parameter  int RD_LAT  = 1,
   parameter  int RST_W   = 16,
   parameter  int MAX_PIX = 63,
   localparam int PC_W    = $clog2(MAX_PIX + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic                    loop_i,
   input  logic                    msb_first_i,
   input  logic [ADDR_W-1:0]       head_addr_i,
   input  logic [RST_W-1:0]        rst_cnt_i,
   output logic                    rd_en_o,
   output logic [ADDR_W-1:0]       rd_addr_o,
   input  logic [ADDR_W+PIX_W-1:0] rd_data_i,
   output logic                    bit_vld_o,
   output logic                    bit_data_o,
   input  logic                    bit_rdy_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [PC_W-1:0]         pix_cnt_o
);

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] head_q,    head_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              msb_q,     msb_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [RST_W-1:0]  sync_cnt_q, sync_cnt_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic              abort_q,   abort_d;
   logic              err_q,     err_d;
   logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;

   logic              load;
   logic              xfer;
   logic              shift_bit;
   logic              shift_last;
   logic [PIX_W-1:0]  pixel_in;
   logic [ADDR_W-1:0] next_in;
   logic [RST_W-1:0]  sync_len;

   assign pixel_in = PIX_W'(word_pixel(WORD_MAX_W'(rd_data_i), PIX_W));
   assign next_in  = ADDR_W'(word_next(WORD_MAX_W'(rd_data_i), PIX_W));
   assign xfer     = (state_q == SEND) && bit_rdy_i;
   assign sync_len = (rst_cnt_q == '0) ? RST_W'(1) : rst_cnt_q;

   ws281x_pix_shifter #(.PIX_W(PIX_W)) u_shifter (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .load_i      (load),
      .pix_i       (pixel_in),
      .msb_first_i (msb_q),
      .shift_i     (xfer),
      .bit_o       (shift_bit),
      .last_o      (shift_last)
   );

   // Next-state logic. rd_addr doubles as the captured next pointer, so the
   // end-of-list test compares it against the latched head. The SYNC counter
   // is loaded centrally on any entry into SYNC.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      rd_addr_d  = rd_addr_q;
      msb_d      = msb_q;
      rst_cnt_d  = rst_cnt_q;
      sync_cnt_d = sync_cnt_q;
      wait_cnt_d = wait_cnt_q;
      abort_d    = abort_q;
      err_d      = err_q;
      pix_cnt_d  = pix_cnt_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               head_d    = head_addr_i;
               rd_addr_d = head_addr_i;
               msb_d     = msb_first_i;
               rst_cnt_d = rst_cnt_i;
               err_d     = 1'b0;
               pix_cnt_d = '0;
               abort_d   = 1'b0;
               state_d   = READ;
            end
         end
         READ: begin
            wait_cnt_d = '0;
            state_d    = WAIT;
            if (abort_i) begin
               abort_d = 1'b1;
               state_d = SYNC;
            end
         end
         WAIT: begin
            if (abort_i) begin
               abort_d = 1'b1;
               state_d = SYNC;
            end else if (wait_cnt_q == 2'(RD_LAT - 1)) begin
               load      = 1'b1;
               rd_addr_d = next_in;
               state_d   = SEND;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         SEND: begin
            if (xfer && shift_last) begin
               pix_cnt_d = pix_cnt_q + PC_W'(1);
               if (rd_addr_q == head_q) begin
                  state_d = SYNC;
               end else if (pix_cnt_d == PC_W'(MAX_PIX)) begin
                  err_d   = 1'b1;
                  state_d = SYNC;
               end else begin
                  state_d = READ;
               end
            end
            if (abort_i) begin
               abort_d = 1'b1;
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (abort_i) begin
               abort_d = 1'b1;
            end
            if (sync_cnt_q == RST_W'(1)) begin
               if (loop_i && !abort_q && !abort_i) begin
                  rd_addr_d = head_q;
                  pix_cnt_d = '0;
                  state_d   = READ;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               sync_cnt_d = sync_cnt_q - RST_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == SYNC) && (state_q != SYNC)) begin
         sync_cnt_d = sync_len;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         head_q     <= '0;
         rd_addr_q  <= '0;
         msb_q      <= 1'b0;
         rst_cnt_q  <= '0;
         sync_cnt_q <= '0;
         wait_cnt_q <= '0;
         abort_q    <= 1'b0;
         err_q      <= 1'b0;
         pix_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         rd_addr_q  <= rd_addr_d;
         msb_q      <= msb_d;
         rst_cnt_q  <= rst_cnt_d;
         sync_cnt_q <= sync_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         abort_q    <= abort_d;
         err_q      <= err_d;
         pix_cnt_q  <= pix_cnt_d;
      end
   end

   // Outputs decode straight from state so a reset drops them immediately.
   assign rd_en_o    = (state_q == READ);
   assign rd_addr_o  = rd_addr_q;
   assign bit_vld_o  = (state_q == SEND);
   assign bit_data_o = bit_vld_o & shift_bit;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == SYNC) && (sync_cnt_q == RST_W'(1));
   assign err_o      = err_q;
   assign pix_cnt_o  = pix_cnt_q;

endmodule

// File: tb/tb_ws281x_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ws281x_chain_ctrl
// Two controller instances share clock and reset:
//   unit 0 : PIX_W=24, RD_LAT=2, MAX_PIX=4
//   unit 1 : PIX_W=32, RD_LAT=1, MAX_PIX=63
// Each has a RAM model whose output is garbage except when a read lands.
// Expected bit streams come from walking the RAM list in the bench.
// ---------------------------------------------------------------------------
module tb_ws281x_chain_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   logic        start [2], abort [2], loop_en [2], msb [2], rdy [2];
   logic [5:0]  head [2];
   logic [15:0] rstc [2];
   logic        rd_en [2], vld [2], bdata [2], busy [2], done [2], err [2];
   logic [5:0]  rd_addr [2];
   logic [5:0]  pix_cnt [2];

   logic [37:0] ram [2][64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : gen_u
      localparam int PW  = (g == 0) ? 24 : 32;
      localparam int RL  = (g == 0) ? 2 : 1;
      localparam int MP  = (g == 0) ? 4 : 63;
      localparam int PCW = $clog2(MP + 1);
      localparam int WW  = 6 + PW;

      logic [WW-1:0]  word_q [2];
      logic [PCW-1:0] pc;

      ws281x_chain_ctrl #(
         .ADDR_W(6), .PIX_W(PW), .RD_LAT(RL), .RST_W(16), .MAX_PIX(MP)
      ) u_dut (
         .clk_i       (clk),
         .rst_n_i     (rst_n),
         .start_i     (start[g]),
         .abort_i     (abort[g]),
         .loop_i      (loop_en[g]),
         .msb_first_i (msb[g]),
         .head_addr_i (head[g]),
         .rst_cnt_i   (rstc[g]),
         .rd_en_o     (rd_en[g]),
         .rd_addr_o   (rd_addr[g]),
         .rd_data_i   (word_q[RL-1]),
         .bit_vld_o   (vld[g]),
         .bit_data_o  (bdata[g]),
         .bit_rdy_i   (rdy[g]),
         .busy_o      (busy[g]),
         .done_o      (done[g]),
         .err_o       (err[g]),
         .pix_cnt_o   (pc)
      );

      assign pix_cnt[g] = 6'(pc);

      // RAM read pipeline; the word is only valid RL cycles after rd_en.
      always @(posedge clk) begin
         if (rd_en[g]) word_q[0] <= WW'(ram[g][rd_addr[g]]);
         else          word_q[0] <= WW'({$urandom, $urandom});
         word_q[1] <= word_q[0];
      end
   end

   function automatic int pw_of(input int u);
      return (u == 0) ? 24 : 32;
   endfunction

   function automatic int rl_of(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic int max_of(input int u);
      return (u == 0) ? 4 : 63;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor, sampled mid-cycle.
   logic got_bits [2][512];
   int   got_n [2], rd_n [2], done_n [2], last_xfer [2], done_cyc [2];
   int   rd_cyc [2][16];
   logic stall_pend [2], stall_bit [2];
   logic rdy_rand [2];
   int   stall_left [2];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!rst_n) begin
            stall_pend[u] = 1'b0;
         end else begin
            if (stall_pend[u]) begin
               checkOutput("hold_vld", 32'(vld[u]), 32'd1);
               checkOutput("hold_bit", 32'(bdata[u]), 32'(stall_bit[u]));
            end
            stall_pend[u] = vld[u] && !rdy[u];
            stall_bit[u]  = bdata[u];
            if (vld[u] && rdy[u]) begin
               if (got_n[u] < 512) got_bits[u][got_n[u]] = bdata[u];
               got_n[u]++;
               last_xfer[u] = cyc;
            end
            if (rd_en[u]) begin
               if (rd_n[u] < 16) rd_cyc[u][rd_n[u]] = cyc;
               rd_n[u]++;
            end
            if (done[u]) begin
               done_n[u]++;
               done_cyc[u] = cyc;
            end
         end
      end
   end

   // Encoder ready: constant 1, or random stalls of 0..5 cycles.
   initial begin
      for (int u = 0; u < 2; u++) begin
         rdy[u] = 1'b1;
         rdy_rand[u] = 1'b0;
         stall_left[u] = 0;
      end
      forever begin
         tick();
         for (int u = 0; u < 2; u++) begin
            if (!rdy_rand[u]) begin
               rdy[u] = 1'b1;
            end else if (stall_left[u] > 0) begin
               rdy[u] = 1'b0;
               stall_left[u]--;
            end else begin
               rdy[u] = 1'b1;
               stall_left[u] = $urandom_range(0, 5);
            end
         end
      end
   end

   // Reference model: walk the list and lay out the bits the strip must see.
   logic exp_bits [512];
   int   exp_n, exp_pix;
   logic exp_err;

   task automatic build_expected(input int u, input logic [5:0] hd, input logic msb_first);
      logic [37:0] w;
      logic [31:0] p;
      logic [5:0]  addr, nxt;
      int pw;
      pw = pw_of(u);
      exp_n = 0; exp_pix = 0; exp_err = 1'b0; addr = hd;
      for (int k = 0; k < 64; k++) begin
         w   = ram[u][addr];
         p   = 32'(w % (38'd1 << pw));
         nxt = 6'(w >> pw);
         for (int i = 0; i < pw; i++) begin
            exp_bits[exp_n] = msb_first ? p[pw-1-i] : p[i];
            exp_n++;
         end
         exp_pix++;
         if (nxt == hd) break;
         if (exp_pix == max_of(u)) begin
            exp_err = 1'b1;
            break;
         end
         addr = nxt;
      end
   endtask

   task automatic set_node(input int u, input logic [5:0] addr, input logic [5:0] nxt, input logic [31:0] pix);
      logic [37:0] p;
      p = 38'(pix) % (38'd1 << pw_of(u));
      ram[u][addr] = (38'(nxt) << pw_of(u)) | p;
   endtask

   task automatic clear_mon(input int u);
      got_n[u] = 0; rd_n[u] = 0; done_n[u] = 0; last_xfer[u] = 0; done_cyc[u] = 0;
   endtask

   task automatic applyStimulus(input int u, input logic [5:0] hd, input logic msb_first,
                                input logic [15:0] rc, input logic lp);
      head[u] = hd; msb[u] = msb_first; rstc[u] = rc; loop_en[u] = lp;
      start[u] = 1'b1;
      tick();
      start[u] = 1'b0;
   endtask

   task automatic wait_idle(input int u, input int budget);
      int n;
      n = 0;
      while (busy[u] && n < budget) begin
         tick();
         n++;
      end
      checkOutput("idle_timeout", 32'(busy[u]), 32'd0);
   endtask

   task automatic wait_bits(input int u, input int k, input int budget);
      int n;
      n = 0;
      while (got_n[u] < k && n < budget) begin
         tick();
         n++;
      end
      checkOutput("bits_timeout", 32'(got_n[u] >= k), 32'd1);
   endtask

   task automatic wait_reads(input int u, input int k, input int budget);
      int n;
      n = 0;
      while (rd_n[u] < k && n < budget) begin
         tick();
         n++;
      end
      checkOutput("read_timeout", 32'(rd_n[u] >= k), 32'd1);
   endtask

   task automatic check_frame(input int u, input string name, input int rc);
      int mism;
      mism = 0;
      for (int j = 0; j < exp_n; j++)
         if (j >= got_n[u] || got_bits[u][j] !== exp_bits[j]) mism++;
      checkOutput({name, "_nbits"}, 32'(got_n[u]), 32'(exp_n));
      checkOutput({name, "_bitmis"}, 32'(mism), 32'd0);
      checkOutput({name, "_pixcnt"}, 32'(pix_cnt[u]), 32'(exp_pix));
      checkOutput({name, "_err"}, 32'(err[u]), 32'(exp_err));
      checkOutput({name, "_done"}, 32'(done_n[u]), 32'd1);
      checkOutput({name, "_synclen"}, 32'(done_cyc[u] - last_xfer[u]), 32'((rc == 0) ? 1 : rc));
   endtask

   task automatic check_quiet(input int u, input string name);
      checkOutput({name, "_busy"}, 32'(busy[u]), 32'd0);
      checkOutput({name, "_vld"}, 32'(vld[u]), 32'd0);
      checkOutput({name, "_rden"}, 32'(rd_en[u]), 32'd0);
      checkOutput({name, "_done"}, 32'(done[u]), 32'd0);
      checkOutput({name, "_err"}, 32'(err[u]), 32'd0);
      checkOutput({name, "_pixcnt"}, 32'(pix_cnt[u]), 32'd0);
      checkOutput({name, "_bit"}, 32'(bdata[u]), 32'd0);
      checkOutput({name, "_rdaddr"}, 32'(rd_addr[u]), 32'd0);
   endtask

   initial begin
      int mism, period, k, base, rc;
      logic [7:0]  first8;
      logic [5:0]  a [4];
      logic        m;

      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b0; abort[u] = 1'b0; loop_en[u] = 1'b0; msb[u] = 1'b0;
         head[u] = '0; rstc[u] = '0;
         clear_mon(u);
         for (int i = 0; i < 64; i++) ram[u][i] = {$urandom, $urandom};
      end
      repeat (3) tick();
      for (int u = 0; u < 2; u++) check_quiet(u, "reset");
      rst_n = 1'b1;
      tick();

      $display("[TB] three-node list, MSB first");
      set_node(0, 6'h05, 6'h09, $urandom);
      set_node(0, 6'h09, 6'h12, $urandom);
      set_node(0, 6'h12, 6'h05, $urandom);
      clear_mon(0);
      build_expected(0, 6'h05, 1'b1);
      applyStimulus(0, 6'h05, 1'b1, 16'd100, 1'b0);
      wait_idle(0, 2000);
      check_frame(0, "list3", 100);
      checkOutput("list3_nbits72", 32'(got_n[0]), 32'd72);

      $display("[TB] GRBW pixel 0xA5, LSB first, random stalls");
      set_node(1, 6'h33, 6'h33, 32'h0000_00A5);
      clear_mon(1);
      rdy_rand[1] = 1'b1;
      build_expected(1, 6'h33, 1'b0);
      applyStimulus(1, 6'h33, 1'b0, 16'd10, 1'b0);
      wait_idle(1, 2000);
      rdy_rand[1] = 1'b0;
      check_frame(1, "grbw", 10);
      first8 = '0;
      for (int i = 0; i < 8; i++) first8 = {first8[6:0], got_bits[1][i]};
      checkOutput("grbw_first8", 32'(first8), 32'h0000_00A5);

      $display("[TB] chain that never returns to head");
      set_node(0, 6'h30, 6'h31, $urandom);
      set_node(0, 6'h31, 6'h32, $urandom);
      set_node(0, 6'h32, 6'h31, $urandom);
      clear_mon(0);
      build_expected(0, 6'h30, 1'b1);
      applyStimulus(0, 6'h30, 1'b1, 16'd12, 1'b0);
      wait_idle(0, 2000);
      check_frame(0, "overrun", 12);
      checkOutput("overrun_pix4", 32'(pix_cnt[0]), 32'd4);
      repeat (20) tick();
      checkOutput("overrun_sticky", 32'(err[0]), 32'd1);
      set_node(0, 6'h20, 6'h20, $urandom);
      clear_mon(0);
      build_expected(0, 6'h20, 1'b0);
      applyStimulus(0, 6'h20, 1'b0, 16'd5, 1'b0);
      checkOutput("err_cleared", 32'(err[0]), 32'd0);
      wait_idle(0, 2000);
      check_frame(0, "after_err", 5);

      $display("[TB] abort mid-pixel with loop enabled");
      set_node(0, 6'h05, 6'h09, $urandom);
      set_node(0, 6'h09, 6'h12, $urandom);
      set_node(0, 6'h12, 6'h05, $urandom);
      clear_mon(0);
      build_expected(0, 6'h05, 1'b1);
      applyStimulus(0, 6'h05, 1'b1, 16'd30, 1'b1);
      wait_bits(0, 10, 200);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      wait_idle(0, 2000);
      loop_en[0] = 1'b0;
      mism = 0;
      for (int j = 0; j < 11; j++) if (got_bits[0][j] !== exp_bits[j]) mism++;
      checkOutput("abort_nbits", 32'(got_n[0]), 32'd11);
      checkOutput("abort_bitmis", 32'(mism), 32'd0);
      checkOutput("abort_done", 32'(done_n[0]), 32'd1);
      checkOutput("abort_synclen", 32'(done_cyc[0] - last_xfer[0]), 32'd30);
      checkOutput("abort_reads", 32'(rd_n[0]), 32'd1);
      checkOutput("abort_pixcnt", 32'(pix_cnt[0]), 32'd0);

      $display("[TB] auto-repeat of a one-pixel list");
      set_node(0, 6'h2A, 6'h2A, $urandom);
      clear_mon(0);
      build_expected(0, 6'h2A, 1'b1);
      applyStimulus(0, 6'h2A, 1'b1, 16'd20, 1'b1);
      wait_reads(0, 2, 500);
      repeat (10) tick();
      head[0] = 6'h05;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wait_reads(0, 4, 500);
      loop_en[0] = 1'b0;
      wait_idle(0, 500);
      period = 1 + rl_of(0) + pw_of(0) + 20;
      checkOutput("loop_frames", 32'(rd_n[0]), 32'd4);
      for (int i = 0; i + 1 < rd_n[0] && i < 15; i++)
         checkOutput("loop_period", 32'(rd_cyc[0][i+1] - rd_cyc[0][i]), 32'(period));
      mism = 0;
      for (int j = 0; j < got_n[0] && j < 512; j++)
         if (got_bits[0][j] !== exp_bits[j % exp_n]) mism++;
      checkOutput("loop_nbits", 32'(got_n[0]), 32'(exp_n * rd_n[0]));
      checkOutput("loop_bitmis", 32'(mism), 32'd0);
      checkOutput("loop_done", 32'(done_n[0]), 32'(rd_n[0]));
      checkOutput("loop_pixcnt", 32'(pix_cnt[0]), 32'd1);

      $display("[TB] zero reset period, then reset during SEND");
      set_node(0, 6'h11, 6'h11, $urandom);
      clear_mon(0);
      build_expected(0, 6'h11, 1'b0);
      applyStimulus(0, 6'h11, 1'b0, 16'd0, 1'b0);
      wait_idle(0, 500);
      check_frame(0, "rst0", 0);
      clear_mon(0);
      applyStimulus(0, 6'h11, 1'b1, 16'd50, 1'b0);
      wait_bits(0, 5, 200);
      rst_n = 1'b0;
      #1;
      check_quiet(0, "async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      clear_mon(0);
      build_expected(0, 6'h11, 1'b1);
      applyStimulus(0, 6'h11, 1'b1, 16'd7, 1'b0);
      checkOutput("restart_rden", 32'(rd_en[0]), 32'd1);
      checkOutput("restart_addr", 32'(rd_addr[0]), 32'h11);
      wait_idle(0, 500);
      check_frame(0, "restart", 7);

      $display("[TB] random lists on the GRBW unit");
      for (int it = 0; it < 5; it++) begin
         k    = $urandom_range(1, 4);
         base = $urandom_range(0, 63);
         for (int i = 0; i < 4; i++) a[i] = 6'(base + 7 * i);
         for (int i = 0; i < k; i++)
            set_node(1, a[i], (i == k - 1) ? a[0] : a[i+1], $urandom);
         m  = 1'($urandom_range(0, 1));
         rc = $urandom_range(0, 40);
         rdy_rand[1] = 1'($urandom_range(0, 1));
         clear_mon(1);
         build_expected(1, a[0], m);
         applyStimulus(1, a[0], m, 16'(rc), 1'b0);
         wait_idle(1, 4000);
         rdy_rand[1] = 1'b0;
         check_frame(1, "rand", rc);
         checkOutput("rand_pixk", 32'(pix_cnt[1]), 32'(k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
